// File: rtl/writeback_arbiter_pkg.sv
// Shared definitions for the completion/writeback path: field widths, the
// completion entry layout and the round-robin pointer step.
package writeback_arbiter_pkg;

   localparam int default_seq_num_bits   = 5;
   localparam int default_phys_addr_bits = 6;
   localparam int arch_addr_bits         = 5;
   localparam int data_bits              = 32;

   typedef struct packed {
      logic [default_seq_num_bits-1:0]   seq_num;
      logic [arch_addr_bits-1:0]         waddr;
      logic [default_phys_addr_bits-1:0] preg;
      logic [data_bits-1:0]              wdata;
      logic                              wen;
   } wb_entry_t;

   // Pointer step with wrap; a single requester always points back at 0.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/writeback_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after rr_ptr,
// pointer moves just past the winner. Reused for fetch and memory ports.
module RRArbiter
   import writeback_arbiter_pkg::*;
#(
   parameter int p_num_reqs = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [p_num_reqs-1:0] req,
   input  logic                  en,
   output logic [p_num_reqs-1:0] gnt
);

   localparam int ptr_bits = (p_num_reqs > 1) ? $clog2(p_num_reqs) : 1;

   logic [ptr_bits-1:0] rr_ptr;
   logic [ptr_bits-1:0] rr_ptr_next;
   logic [ptr_bits-1:0] cand;
   logic                found;
   int                  idx;

   // Cyclic scan starting at rr_ptr; the first requester found wins.
   always_comb begin
      gnt         = '0;
      rr_ptr_next = rr_ptr;
      found       = 1'b0;
      idx         = 0;
      cand        = '0;
      if (en) begin
         for (int off = 0; off < p_num_reqs; off++) begin
            idx = int'(rr_ptr) + off;
            if (idx >= p_num_reqs) begin
               idx = idx - p_num_reqs;
            end
            cand = ptr_bits'(idx);
            if (!found && req[cand]) begin
               found       = 1'b1;
               gnt[cand]   = 1'b1;
               rr_ptr_next = ptr_bits'(rr_next(idx, p_num_reqs));
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr <= '0;
      end else if (en && |req) begin
         rr_ptr <= rr_ptr_next;
      end
   end

endmodule

// File: rtl/writeback_arbiter.sv
// Shares the single completion/writeback port among the execute pipes through
// per-pipe one-entry holding registers and a round-robin grant.
module writeback_arbiter
   import writeback_arbiter_pkg::*;
#(
   parameter int p_num_pipes      = 2,
   parameter int p_seq_num_bits   = default_seq_num_bits,
   parameter int p_phys_addr_bits = default_phys_addr_bits
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [p_num_pipes-1:0]                wb_val,
   output logic [p_num_pipes-1:0]                wb_rdy,
   input  logic [p_num_pipes*p_seq_num_bits-1:0] wb_seq_num,
   input  logic [p_num_pipes*arch_addr_bits-1:0] wb_waddr,
   input  logic [p_num_pipes*p_phys_addr_bits-1:0] wb_preg,
   input  logic [p_num_pipes*data_bits-1:0]      wb_wdata,
   input  logic [p_num_pipes-1:0]                wb_wen,
   output logic                                  complete_val,
   output logic [p_seq_num_bits-1:0]             complete_seq_num,
   output logic [arch_addr_bits-1:0]             complete_waddr,
   output logic [p_phys_addr_bits-1:0]           complete_preg,
   output logic [data_bits-1:0]                  complete_wdata,
   output logic                                  complete_wen
);

   typedef struct packed {
      logic [p_seq_num_bits-1:0]   seq_num;
      logic [arch_addr_bits-1:0]   waddr;
      logic [p_phys_addr_bits-1:0] preg;
      logic [data_bits-1:0]        wdata;
      logic                        wen;
   } hold_entry_t;

   hold_entry_t            incoming [p_num_pipes];
   hold_entry_t            hold     [p_num_pipes];
   hold_entry_t            sel;
   logic [p_num_pipes-1:0] hold_val;
   logic [p_num_pipes-1:0] grant;

   always_comb begin
      for (int i = 0; i < p_num_pipes; i++) begin
         incoming[i].seq_num = wb_seq_num[i*p_seq_num_bits +: p_seq_num_bits];
         incoming[i].waddr   = wb_waddr[i*arch_addr_bits +: arch_addr_bits];
         incoming[i].preg    = wb_preg[i*p_phys_addr_bits +: p_phys_addr_bits];
         incoming[i].wdata   = wb_wdata[i*data_bits +: data_bits];
         incoming[i].wen     = wb_wen[i];
      end
   end

   // Requests come only from holding registers, keeping wb_val off the wb_rdy path.
   RRArbiter #(
      .p_num_reqs(p_num_pipes)
   ) u_rr (
      .clk(clk),
      .rst(rst),
      .req(hold_val),
      .en (1'b1),
      .gnt(grant)
   );

   assign wb_rdy = ~hold_val | grant;

   // A granted entry can be refilled in the same cycle, so one pipe sustains full rate.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_val <= '0;
         for (int i = 0; i < p_num_pipes; i++) begin
            hold[i] <= '0;
         end
      end else begin
         for (int i = 0; i < p_num_pipes; i++) begin
            if (wb_val[i] && wb_rdy[i]) begin
               hold_val[i] <= 1'b1;
               hold[i]     <= incoming[i];
            end else if (grant[i]) begin
               hold_val[i] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      sel = '0;
      for (int i = 0; i < p_num_pipes; i++) begin
         if (grant[i]) begin
            sel = hold[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         complete_val     <= 1'b0;
         complete_seq_num <= '0;
         complete_waddr   <= '0;
         complete_preg    <= '0;
         complete_wdata   <= '0;
         complete_wen     <= 1'b0;
      end else begin
         complete_val     <= |grant;
         complete_seq_num <= sel.seq_num;
         complete_waddr   <= sel.waddr;
         complete_preg    <= sel.preg;
         complete_wdata   <= sel.wdata;
         complete_wen     <= sel.wen;
      end
   end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: a 2-pipe and a 3-pipe instance share
// clock and reset; expected completions are worked out by hand per scenario.
module tb_writeback_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [1:0]  a_val, a_rdy, a_wen;
   logic [9:0]  a_seq, a_waddr;
   logic [11:0] a_preg;
   logic [63:0] a_wdata;
   logic        a_cval, a_cwen;
   logic [4:0]  a_cseq, a_cwaddr;
   logic [5:0]  a_cpreg;
   logic [31:0] a_cwdata;

   logic [2:0]  b_val, b_rdy, b_wen;
   logic [14:0] b_seq, b_waddr;
   logic [17:0] b_preg;
   logic [95:0] b_wdata;
   logic        b_cval, b_cwen;
   logic [4:0]  b_cseq, b_cwaddr;
   logic [5:0]  b_cpreg;
   logic [31:0] b_cwdata;

   int vectors = 0;
   int miscompares = 0;

   writeback_arbiter #(.p_num_pipes(2), .p_seq_num_bits(5), .p_phys_addr_bits(6)) dut_a (
      .clk(clk), .rst(rst), .wb_val(a_val), .wb_rdy(a_rdy), .wb_seq_num(a_seq),
      .wb_waddr(a_waddr), .wb_preg(a_preg), .wb_wdata(a_wdata), .wb_wen(a_wen),
      .complete_val(a_cval), .complete_seq_num(a_cseq), .complete_waddr(a_cwaddr),
      .complete_preg(a_cpreg), .complete_wdata(a_cwdata), .complete_wen(a_cwen)
   );

   writeback_arbiter #(.p_num_pipes(3), .p_seq_num_bits(5), .p_phys_addr_bits(6)) dut_b (
      .clk(clk), .rst(rst), .wb_val(b_val), .wb_rdy(b_rdy), .wb_seq_num(b_seq),
      .wb_waddr(b_waddr), .wb_preg(b_preg), .wb_wdata(b_wdata), .wb_wen(b_wen),
      .complete_val(b_cval), .complete_seq_num(b_cseq), .complete_waddr(b_cwaddr),
      .complete_preg(b_cpreg), .complete_wdata(b_cwdata), .complete_wen(b_cwen)
   );

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int p, input logic [4:0] seq, input logic [4:0] waddr,
                                input logic [5:0] preg, input logic [31:0] wdata, input logic wen);
      a_seq[p*5 +: 5]    = seq;
      a_waddr[p*5 +: 5]  = waddr;
      a_preg[p*6 +: 6]   = preg;
      a_wdata[p*32 +: 32] = wdata;
      a_wen[p]           = wen;
      a_val[p]           = 1'b1;
   endtask

   task automatic doReset();
      rst   = 1'b0;
      a_val = '0;
      b_val = '0;
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      tick();
   endtask

   int cntIn [32];
   int cntOut[32];
   int idCount[100];
   int gotPipe[3];

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "[TB] simulation time limit");
   end

   initial begin
      int sent, recv, cycles, stray, bad;
      bit act [2];
      logic [1:0] rdySnap;
      logic [4:0] seqExp;

      rst = 1'b1;
      a_val = '0; a_seq = '0; a_waddr = '0; a_preg = '0; a_wdata = '0; a_wen = '0;
      b_val = '0; b_seq = '0; b_waddr = '0; b_preg = '0; b_wdata = '0; b_wen = '0;
      #1 rst = 1'b0;
      #2;
      checkOutput("rst_a_cval", a_cval, 0);
      checkOutput("rst_a_rdy", a_rdy, 2'b11);
      checkOutput("rst_b_rdy", b_rdy, 3'b111);
      checkOutput("rst_a_wdata", a_cwdata, 0);
      checkOutput("rst_b_cval", b_cval, 0);
      doReset();

      // Single transfer: completion two edges later with identical fields.
      applyStimulus(0, 5'd3, 5'd5, 6'd7, 32'hDEADBEEF, 1'b1);
      checkOutput("single_rdy_t0", a_rdy[0], 1);
      tick();
      a_val = '0;
      checkOutput("single_rdy_t1", a_rdy[0], 1);
      checkOutput("single_cval_t1", a_cval, 0);
      tick();
      checkOutput("single_cval_t2", a_cval, 1);
      checkOutput("single_seq", a_cseq, 5'd3);
      checkOutput("single_waddr", a_cwaddr, 5'd5);
      checkOutput("single_preg", a_cpreg, 6'd7);
      checkOutput("single_wdata", a_cwdata, 32'hDEADBEEF);
      checkOutput("single_wen", a_cwen, 1);
      checkOutput("single_rdy_t2", a_rdy[0], 1);
      tick();
      checkOutput("single_cval_t3", a_cval, 0);
      checkOutput("single_wdata_zero", a_cwdata, 0);

      // Two-way conflict; pipe 0 refills while pipe 1 waits, then pipe 1 wins.
      doReset();
      applyStimulus(0, 5'd1, 5'd1, 6'd1, 32'h1111, 1'b1);
      applyStimulus(1, 5'd2, 5'd2, 6'd2, 32'h2222, 1'b1);
      tick();
      a_val = '0;
      checkOutput("conf_rdy_blocked", a_rdy, 2'b01);
      applyStimulus(0, 5'd3, 5'd3, 6'd3, 32'h3333, 1'b1);
      tick();
      a_val = '0;
      checkOutput("conf_cval_1", a_cval, 1);
      checkOutput("conf_seq_1", a_cseq, 5'd1);
      checkOutput("conf_rdy_after", a_rdy, 2'b10);
      tick();
      checkOutput("conf_seq_2", a_cseq, 5'd2);
      checkOutput("conf_wdata_2", a_cwdata, 32'h2222);
      tick();
      checkOutput("conf_seq_3", a_cseq, 5'd3);
      checkOutput("conf_cval_3", a_cval, 1);
      tick();
      checkOutput("conf_idle", a_cval, 0);

      // Completion without register write is still broadcast.
      applyStimulus(0, 5'd9, 5'd0, 6'd0, 32'h1234, 1'b0);
      tick();
      a_val = '0;
      tick();
      checkOutput("nowb_cval", a_cval, 1);
      checkOutput("nowb_wen", a_cwen, 0);
      checkOutput("nowb_seq", a_cseq, 5'd9);
      tick();

      // Sustained contention on three pipes for 12 transfer edges.
      doReset();
      for (int p = 0; p < 3; p++) begin
         b_seq[p*5 +: 5]     = 5'(p + 1);
         b_waddr[p*5 +: 5]   = 5'(p);
         b_preg[p*6 +: 6]    = 6'(p + 10);
         b_wdata[p*32 +: 32] = 32'(32'h100 * (p + 1));
         b_wen[p]            = 1'b1;
         gotPipe[p]          = 0;
      end
      b_val = 3'b111;
      for (int k = 1; k <= 13; k++) begin
         if (k == 13) b_val = '0;
         tick();
         checkOutput($sformatf("rot_cval_%0d", k), b_cval, (k >= 2) ? 1 : 0);
         if (k >= 2) begin
            seqExp = 5'(((k - 2) % 3) + 1);
            checkOutput($sformatf("rot_seq_%0d", k), b_cseq, seqExp);
         end
         if (k <= 12) begin
            checkOutput($sformatf("rot_rdy_%0d", k), b_rdy, 3'b001 << ((k - 1) % 3));
         end
         if (b_cval && b_cseq >= 5'd1 && b_cseq <= 5'd3) gotPipe[b_cseq - 5'd1]++;
      end
      for (int p = 0; p < 3; p++) checkOutput($sformatf("rot_count_%0d", p), gotPipe[p], 4);
      tick();
      checkOutput("rot_drain_0", b_cseq, 5'd1);
      checkOutput("rot_drain_wdata", b_cwdata, 32'h100);
      tick();
      checkOutput("rot_drain_1", b_cseq, 5'd2);
      tick();
      checkOutput("rot_drain_idle", b_cval, 0);

      // Random back-pressure with a seq/id scoreboard.
      doReset();
      for (int v = 0; v < 32; v++) begin cntIn[v] = 0; cntOut[v] = 0; end
      for (int v = 0; v < 100; v++) idCount[v] = 0;
      sent = 0; recv = 0; cycles = 0; stray = 0;
      act[0] = 1'b0; act[1] = 1'b0;
      while (recv < 100 && cycles < 3000) begin
         for (int p = 0; p < 2; p++) begin
            if (!act[p] && sent < 100 && $urandom_range(0, 3) != 0) begin
               applyStimulus(p, 5'(sent), 5'(p), 6'(sent), 32'h00C00000 | 32'(sent), 1'b1);
               act[p] = 1'b1;
               sent++;
            end
         end
         a_val   = {act[1], act[0]};
         rdySnap = a_rdy;
         tick();
         cycles++;
         for (int p = 0; p < 2; p++) begin
            if (act[p] && rdySnap[p]) begin
               cntIn[a_seq[p*5 +: 5]]++;
               act[p] = 1'b0;
            end
         end
         a_val = {act[1], act[0]};
         if (a_cval) begin
            cntOut[a_cseq]++;
            recv++;
            if (a_cwdata[15:0] < 16'd100) idCount[a_cwdata[15:0]]++;
            else stray++;
         end
      end
      a_val = '0;
      checkOutput("bp_count", recv, 100);
      bad = stray;
      for (int v = 0; v < 100; v++) if (idCount[v] != 1) bad++;
      checkOutput("bp_lost_or_dup", bad, 0);
      bad = 0;
      for (int v = 0; v < 32; v++) if (cntIn[v] != cntOut[v]) bad++;
      checkOutput("bp_seq_multiset", bad, 0);
      tick();
      tick();

      // Asynchronous reset with two entries held and a completion on the output.
      doReset();
      applyStimulus(0, 5'd10, 5'd1, 6'd1, 32'hA0, 1'b1);
      applyStimulus(1, 5'd11, 5'd2, 6'd2, 32'hA1, 1'b1);
      tick();
      a_val = '0;
      applyStimulus(0, 5'd12, 5'd3, 6'd3, 32'hA2, 1'b1);
      tick();
      a_val = '0;
      checkOutput("arst_pre_seq", a_cseq, 5'd10);
      #3 rst = 1'b0;
      #1;
      checkOutput("arst_cval", a_cval, 0);
      checkOutput("arst_seq", a_cseq, 0);
      checkOutput("arst_wdata", a_cwdata, 0);
      checkOutput("arst_rdy", a_rdy, 2'b11);
      tick();
      checkOutput("arst_hold_cval", a_cval, 0);
      #2 rst = 1'b1;
      applyStimulus(0, 5'd20, 5'd4, 6'd4, 32'hB0, 1'b1);
      applyStimulus(1, 5'd21, 5'd5, 6'd5, 32'hB1, 1'b1);
      tick();
      a_val = '0;
      checkOutput("arst_post_idle", a_cval, 0);
      tick();
      checkOutput("arst_post_first", a_cseq, 5'd20);
      tick();
      checkOutput("arst_post_second", a_cseq, 5'd21);
      tick();
      checkOutput("arst_post_drain", a_cval, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
